// File: rtl/serial_addsub.sv
// Bit-serial A+B / A-B, DIGIT bits per cycle LSB first; result after N=WIDTH/DIGIT ADD cycles, held until out_ready.
// in_ready only in IDLE (no queueing). Define SERIAL_ADDSUB_SAT_EN for signed saturation of overflowing results.
module serial_addsub #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = $clog2(N) + 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ADD  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             carry_q, carry_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             out_valid_q, out_valid_d;

    logic [DIGIT:0]   slice;
    logic [DIGIT-1:0] slice_s;
    logic             slice_c;
    logic             slice_ovf;
    logic [WIDTH-1:0] sum_shift;
    logic [WIDTH-1:0] final_sum;
    logic             last;

    assign slice   = {1'b0, a_q[DIGIT-1:0]} + {1'b0, b_q[DIGIT-1:0]} + {{DIGIT{1'b0}}, carry_q};
    assign slice_s = slice[DIGIT-1:0];
    assign slice_c = slice[DIGIT];

    // Carry into the slice MSB is recovered from the MSB sum bit, so no DIGIT==1 special case.
    assign slice_ovf = slice_c ^ (slice_s[DIGIT-1] ^ a_q[DIGIT-1] ^ b_q[DIGIT-1]);

    assign sum_shift = (sum_q >> DIGIT) | (WIDTH'(slice_s) << (WIDTH - DIGIT));
    assign last      = (count_q == CW'(N - 1));

`ifdef SERIAL_ADDSUB_SAT_EN
    // In the final slice a_q[DIGIT-1] is still A's sign bit, which is the sign of the true result on overflow.
    logic [WIDTH-1:0] sat_val;
    assign sat_val   = a_q[DIGIT-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    assign final_sum = slice_ovf ? sat_val : sum_shift;
`else
    assign final_sum = sum_shift;
`endif

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        carry_d     = carry_q;
        count_d     = count_q;
        sum_d       = sum_q;
        cout_d      = cout_q;
        ovf_d       = ovf_q;
        out_valid_d = out_valid_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = sub ? ~b : b;
                    carry_d = sub;
                    count_d = '0;
                    sum_d   = '0;
                    state_d = S_ADD;
                end
            end
            S_ADD: begin
                a_d     = a_q >> DIGIT;
                b_d     = b_q >> DIGIT;
                carry_d = slice_c;
                count_d = count_q + CW'(1);
                sum_d   = sum_shift;
                if (last) begin
                    sum_d       = final_sum;
                    cout_d      = slice_c;
                    ovf_d       = slice_ovf;
                    out_valid_d = 1'b1;
                    state_d     = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                state_d     = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            a_q         <= '0;
            b_q         <= '0;
            carry_q     <= 1'b0;
            count_q     <= '0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            carry_q     <= carry_d;
            count_q     <= count_d;
            sum_q       <= sum_d;
            cout_q      <= cout_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_serial_addsub.sv
// Directed bench for serial_addsub: an 8-bit/1-bit-digit instance and a 16-bit/4-bit-digit instance.
module tb_serial_addsub;

`ifdef SERIAL_ADDSUB_SAT_EN
    localparam logic [7:0]  E_3C5A = 8'h7F;
    localparam logic [7:0]  E_8001 = 8'h80;
    localparam logic [7:0]  E_7F01 = 8'h7F;
    localparam logic [15:0] E_7010 = 16'h7FFF;
`else
    localparam logic [7:0]  E_3C5A = 8'h96;
    localparam logic [7:0]  E_8001 = 8'h7F;
    localparam logic [7:0]  E_7F01 = 8'h80;
    localparam logic [15:0] E_7010 = 16'h8000;
`endif

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic       iv8, ir8, sub8, ov8, or8, co8, of8;
    logic [7:0] a8, b8, s8;
    logic        iv16, ir16, sub16, ov16, or16, co16, of16;
    logic [15:0] a16, b16, s16;

    int errors = 0;
    int checks = 0;

    serial_addsub #(.WIDTH(8), .DIGIT(1)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8), .sub(sub8),
        .out_valid(ov8), .out_ready(or8), .sum(s8), .cout(co8), .ovf(of8)
    );

    serial_addsub #(.WIDTH(16), .DIGIT(4)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ir16), .a(a16), .b(b16), .sub(sub16),
        .out_valid(ov16), .out_ready(or16), .sum(s16), .cout(co16), .ovf(of16)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic cur_ir(input bit wide);
        return wide ? ir16 : ir8;
    endfunction

    function automatic logic cur_ov(input bit wide);
        return wide ? ov16 : ov8;
    endfunction

    // Accept one op and step to DONE, checking handshake timing on the way.
    task automatic run_op(input bit wide, input logic [15:0] av, input logic [15:0] bv, input logic s);
        int n;
        n = wide ? 4 : 8;
        for (int i = 0; i < 20 && !cur_ir(wide); i++) tick();
        check("in_ready_before_accept", 32'(cur_ir(wide)), 32'd1);
        if (wide) begin
            a16 = av; b16 = bv; sub16 = s; iv16 = 1'b1;
        end else begin
            a8 = av[7:0]; b8 = bv[7:0]; sub8 = s; iv8 = 1'b1;
        end
        tick();
        iv8 = 1'b0; iv16 = 1'b0;
        for (int i = 0; i < n - 1; i++) begin
            check("in_ready_busy", 32'(cur_ir(wide)), 32'd0);
            tick();
        end
        check("out_valid_early", 32'(cur_ov(wide)), 32'd0);
        tick();
        check("out_valid_latency", 32'(cur_ov(wide)), 32'd1);
        check("in_ready_done", 32'(cur_ir(wide)), 32'd0);
    endtask

    task automatic consume(input bit wide);
        or8 = !wide; or16 = wide;
        tick();
        or8 = 1'b0; or16 = 1'b0;
        check("out_valid_consumed", 32'(cur_ov(wide)), 32'd0);
        check("in_ready_after_consume", 32'(cur_ir(wide)), 32'd1);
    endtask

    initial begin
        rst_n = 1'b0;
        iv8 = 1'b0; a8 = '0; b8 = '0; sub8 = 1'b0; or8 = 1'b0;
        iv16 = 1'b0; a16 = '0; b16 = '0; sub16 = 1'b0; or16 = 1'b0;
        tick();
        tick();
        check("rst_in_ready", 32'(ir8), 32'd1);
        check("rst_out_valid", 32'(ov8), 32'd0);
        check("rst_sum", 32'(s8), 32'd0);
        check("rst_cout", 32'(co8), 32'd0);
        check("rst_ovf", 32'(of8), 32'd0);
        check("rst_out_valid16", 32'(ov16), 32'd0);
        rst_n = 1'b1;

        run_op(1'b0, 16'h3C, 16'h5A, 1'b0);
        check("3C+5A_sum", 32'(s8), 32'(E_3C5A));
        check("3C+5A_cout", 32'(co8), 32'd0);
        check("3C+5A_ovf", 32'(of8), 32'd1);
        consume(1'b0);

        run_op(1'b0, 16'hFF, 16'h01, 1'b0);
        check("FF+01_sum", 32'(s8), 32'h00);
        check("FF+01_cout", 32'(co8), 32'd1);
        check("FF+01_ovf", 32'(of8), 32'd0);
        consume(1'b0);

        run_op(1'b0, 16'h10, 16'h20, 1'b1);
        check("10-20_sum", 32'(s8), 32'hF0);
        check("10-20_cout", 32'(co8), 32'd0);
        check("10-20_ovf", 32'(of8), 32'd0);
        consume(1'b0);

        run_op(1'b0, 16'h80, 16'h01, 1'b1);
        check("80-01_sum", 32'(s8), 32'(E_8001));
        check("80-01_cout", 32'(co8), 32'd1);
        check("80-01_ovf", 32'(of8), 32'd1);
        consume(1'b0);

        // Backpressure: result held while a new request waits on in_valid.
        run_op(1'b0, 16'hC0, 16'h50, 1'b0);
        a8 = 8'h01; b8 = 8'h02; sub8 = 1'b0; iv8 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_sum_stable", 32'(s8), 32'h10);
            check("bp_out_valid", 32'(ov8), 32'd1);
            check("bp_in_ready", 32'(ir8), 32'd0);
        end
        check("C0+50_cout", 32'(co8), 32'd1);
        check("C0+50_ovf", 32'(of8), 32'd0);
        or8 = 1'b1;
        tick();
        or8 = 1'b0;
        check("bp_release_out_valid", 32'(ov8), 32'd0);
        check("bp_release_in_ready", 32'(ir8), 32'd1);
        tick();
        iv8 = 1'b0;
        check("bp_next_accepted", 32'(ir8), 32'd0);
        check("cout_hold_in_add", 32'(co8), 32'd1);
        for (int i = 0; i < 7; i++) tick();
        check("01+02_early", 32'(ov8), 32'd0);
        tick();
        check("01+02_valid", 32'(ov8), 32'd1);
        check("01+02_sum", 32'(s8), 32'h03);
        check("01+02_cout", 32'(co8), 32'd0);
        consume(1'b0);

        // Reset while count==3 in ADD.
        a8 = 8'h55; b8 = 8'h11; sub8 = 1'b0; iv8 = 1'b1;
        tick();
        iv8 = 1'b0;
        tick(); tick(); tick();
        check("midadd_busy", 32'(ir8), 32'd0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("midrst_in_ready", 32'(ir8), 32'd1);
        check("midrst_out_valid", 32'(ov8), 32'd0);
        check("midrst_sum", 32'(s8), 32'd0);
        run_op(1'b0, 16'h7F, 16'h01, 1'b0);
        check("7F+01_sum", 32'(s8), 32'(E_7F01));
        check("7F+01_cout", 32'(co8), 32'd0);
        check("7F+01_ovf", 32'(of8), 32'd1);
        consume(1'b0);

        run_op(1'b1, 16'h1234, 16'h0FCD, 1'b0);
        check("1234+0FCD_sum", 32'(s16), 32'h2201);
        check("1234+0FCD_cout", 32'(co16), 32'd0);
        check("1234+0FCD_ovf", 32'(of16), 32'd0);
        consume(1'b1);

        run_op(1'b1, 16'h0001, 16'h0002, 1'b1);
        check("0001-0002_sum", 32'(s16), 32'hFFFF);
        check("0001-0002_cout", 32'(co16), 32'd0);
        check("0001-0002_ovf", 32'(of16), 32'd0);
        consume(1'b1);

        run_op(1'b1, 16'h7000, 16'h1000, 1'b0);
        check("7000+1000_sum", 32'(s16), 32'(E_7010));
        check("7000+1000_cout", 32'(co16), 32'd0);
        check("7000+1000_ovf", 32'(of16), 32'd1);
        consume(1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
